// File: rtl/signal_mux_pkg.sv
// Shared definitions for the signal mux scheduler slice.
//   SEL_*      : mux select codes for each source and for the idle (4'hF) input
//   sched_st_t : scheduler state encoding
//   idx_to_sel : maps a requester index (req bit position) to its mux code
package signal_mux_pkg;

  localparam logic [3:0] SEL_A    = 4'd2;
  localparam logic [3:0] SEL_B    = 4'd0;
  localparam logic [3:0] SEL_D    = 4'd3;
  localparam logic [3:0] SEL_E    = 4'd1;
  localparam logic [3:0] SEL_IDLE = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } sched_st_t;

  // req bit order is A, B, D, E; the mux codes are not in that order.
  function automatic logic [3:0] idx_to_sel(input logic [1:0] idx);
    logic [3:0] code;
    case (idx)
      2'd0:    code = SEL_A;
      2'd1:    code = SEL_B;
      2'd2:    code = SEL_D;
      default: code = SEL_E;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/signal_rr_pick.sv
// Combinational rotating-priority picker.
//   req   : request vector (bit0=A, bit1=B, bit2=D, bit3=E)
//   ptr   : index with highest priority; scan proceeds ptr, ptr+1, ... mod 4
//   valid : at least one request is set
//   idx   : index of the first set request in scan order (0 when !valid)
module signal_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/signal_mux_scheduler.sv
// Round-robin scheduler driving the select code of the 4-input signal mux.
// Each winner holds the mux for HOLD_CYCLES cycles (less if it drops its
// request), followed by one idle cycle with the mux on its 4'hF input.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   req   : request per source (bit0=A, bit1=B, bit2=D, bit3=E)
//   sel   : registered mux select code (SEL_IDLE when not granting)
//   grant : registered one-hot grant in req bit order, 0 when idle
//   busy  : high while granting
//   done  : pulse in the final cycle of a full-length grant
module signal_mux_scheduler
  import signal_mux_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 3,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] sel,
  output logic [3:0] grant,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  sched_st_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       gidx_q, gidx_d;
  logic [3:0]       sel_d;
  logic [3:0]       grant_d;
  logic             busy_d;
  logic             done_d;

  logic             pick_valid;
  logic [1:0]       pick_idx;

  signal_rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      sel     <= SEL_IDLE;
      grant   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      sel     <= sel_d;
      grant   <= grant_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Outputs are computed for the cycle being entered, so done is raised on
  // the edge that starts the last cycle of a grant (cnt reaching zero).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    sel_d   = SEL_IDLE;
    grant_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (pick_valid) begin
          state_d = ST_GRANT;
          gidx_d  = pick_idx;
          cnt_d   = HOLD_LOAD;
          sel_d   = idx_to_sel(pick_idx);
          grant_d = 4'b0001 << pick_idx;
          busy_d  = 1'b1;
          done_d  = (HOLD_LOAD == '0);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GRANT: begin
        if (!req[gidx_q] || (cnt_q == '0)) begin
          state_d = ST_GAP;
          ptr_d   = gidx_q + 2'd1;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          sel_d   = idx_to_sel(gidx_q);
          grant_d = 4'b0001 << gidx_q;
          busy_d  = 1'b1;
          done_d  = (cnt_q == CNT_W'(1));
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_signal_mux_scheduler.sv
module tb_signal_mux_scheduler;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] sel0, grant0, sel1, grant1;
  logic       busy0, done0, busy1, done1;

  signal_mux_scheduler #(.HOLD_CYCLES(3), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel0), .grant(grant0), .busy(busy0), .done(done0)
  );

  signal_mux_scheduler #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .sel(sel1), .grant(grant1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream mux data inputs and a behavioural mux on dut0's select.
  localparam logic [3:0] DA = 4'h5, DB = 4'hA, DD = 4'h3, DE = 4'hC;
  logic [3:0] q0;
  always_comb begin
    case (sel0)
      4'd0:    q0 = DB;
      4'd1:    q0 = DE;
      4'd2:    q0 = DA;
      4'd3:    q0 = DD;
      default: q0 = 4'hF;
    endcase
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst_n = 1'b0;
    req   = r;
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: owner is the served index (-1 when none), left is the
  // number of grant cycles remaining including the current one.
  int m_owner[2] = '{-1, -1};
  int m_left [2] = '{0, 0};
  int m_ptr  [2] = '{0, 0};
  int m_hold [2] = '{3, 1};
  int m_code [4] = '{2, 0, 3, 1};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_owner[u] = -1;
        m_left[u]  = 0;
        m_ptr[u]   = 0;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        if (m_owner[u] >= 0) begin
          if (!req[m_owner[u]] || m_left[u] == 1) begin
            m_ptr[u]   = (m_owner[u] + 1) % 4;
            m_owner[u] = -1;
          end else begin
            m_left[u] = m_left[u] - 1;
          end
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (m_owner[u] < 0 && req[(m_ptr[u] + k) % 4]) begin
              m_owner[u] = (m_ptr[u] + k) % 4;
              m_left[u]  = m_hold[u];
            end
          end
        end
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        int e_sel, e_grant, e_busy, e_done;
        e_sel   = (m_owner[u] < 0) ? 4 : m_code[m_owner[u]];
        e_grant = (m_owner[u] < 0) ? 0 : (1 << m_owner[u]);
        e_busy  = (m_owner[u] >= 0) ? 1 : 0;
        e_done  = (m_owner[u] >= 0 && m_left[u] == 1) ? 1 : 0;
        chk($sformatf("model_sel[%0d]", u),   int'(u == 0 ? sel0 : sel1), e_sel);
        chk($sformatf("model_grant[%0d]", u), int'(u == 0 ? grant0 : grant1), e_grant);
        chk($sformatf("model_busy[%0d]", u),  int'(u == 0 ? busy0 : busy1), e_busy);
        chk($sformatf("model_done[%0d]", u),  int'(u == 0 ? done0 : done1), e_done);
      end
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    logic [3:0] sel1;
    logic       done1;
  } vec_t;

  vec_t tbl[8];

  int seq3_sel[16] = '{2,2,4,0,0,0,4,3,3,3,4,1,1,1,4,2};
  int seq3_q  [16] = '{5,5,15,10,10,10,15,3,3,3,15,12,12,12,15,5};
  int seq6_sel[12] = '{1,1,4,2,2,2,4,1,1,1,4,2};

  initial begin
    // Single B requester: dut0 holds 3 cycles, dut1 holds 1 cycle.
    tbl[0] = '{4'b0010, 4'd0, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b1};
    tbl[1] = '{4'b0010, 4'd0, 4'b0010, 1'b1, 1'b0, 4'd4, 1'b0};
    tbl[2] = '{4'b0010, 4'd0, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[3] = '{4'b0010, 4'd4, 4'b0000, 1'b0, 1'b0, 4'd4, 1'b0};
    tbl[4] = '{4'b0010, 4'd0, 4'b0010, 1'b1, 1'b0, 4'd0, 1'b1};
    tbl[5] = '{4'b0010, 4'd0, 4'b0010, 1'b1, 1'b0, 4'd4, 1'b0};
    tbl[6] = '{4'b0010, 4'd0, 4'b0010, 1'b1, 1'b1, 4'd0, 1'b1};
    tbl[7] = '{4'b0010, 4'd4, 4'b0000, 1'b0, 1'b0, 4'd4, 1'b0};

    // Reset with every source requesting.
    rst_n = 1'b0;
    req   = 4'hF;
    tick();
    tick();
    chk("rst_sel",   int'(sel0),   4);
    chk("rst_grant", int'(grant0), 0);
    chk("rst_busy",  int'(busy0),  0);
    chk("rst_done",  int'(done0),  0);
    chk("rst_q",     int'(q0),     15);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    tick();
    chk("first_sel",   int'(sel0),   2);
    chk("first_grant", int'(grant0), 1);

    // All requesting: A, B, D, E, A with gaps.
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("all_sel[%0d]", i), int'(sel0), seq3_sel[i]);
      chk($sformatf("all_q[%0d]", i),   int'(q0),   seq3_q[i]);
    end

    // Single B requester table.
    do_reset(4'b0010);
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req;
      tick();
      chk($sformatf("tbl_sel[%0d]", i),   int'(sel0),   int'(tbl[i].sel));
      chk($sformatf("tbl_grant[%0d]", i), int'(grant0), int'(tbl[i].grant));
      chk($sformatf("tbl_busy[%0d]", i),  int'(busy0),  int'(tbl[i].busy));
      chk($sformatf("tbl_done[%0d]", i),  int'(done0),  int'(tbl[i].done));
      chk($sformatf("tbl_sel1[%0d]", i),  int'(sel1),   int'(tbl[i].sel1));
      chk($sformatf("tbl_done1[%0d]", i), int'(done1),  int'(tbl[i].done1));
    end

    // Early drop of D while E waits.
    do_reset(4'b0100);
    tick();
    chk("drop_dsel", int'(sel0), 3);
    req = 4'b1000;
    tick();
    chk("drop_grant", int'(grant0), 0);
    chk("drop_sel",   int'(sel0),   4);
    chk("drop_done",  int'(done0),  0);
    tick();
    chk("drop_next_sel",   int'(sel0),   1);
    chk("drop_next_grant", int'(grant0), 8);

    // Asynchronous reset in the middle of the E grant.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel",   int'(sel0),   4);
    chk("arst_grant", int'(grant0), 0);
    chk("arst_busy",  int'(busy0),  0);
    req = 4'b1000;
    #3;
    rst_n = 1'b1;
    tick();
    chk("arst_e_sel",   int'(sel0),   1);
    chk("arst_e_grant", int'(grant0), 8);

    // Fairness between A and E.
    do_reset(4'b1000);
    tick();
    chk("fair_first", int'(sel0), 1);
    req = 4'b1001;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("fair_sel[%0d]", i), int'(sel0), seq6_sel[i]);
    end

    // Randomized traffic with occasional mid-cycle resets.
    do_reset(4'b0000);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) begin
        #1;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
